// File: rtl/pc_if_id_stage.sv
// PC register and IF/ID pipeline latch around the combinational fetch stage.
// Handles stall, branch redirect with a one-bubble flush, and halt detection.
module pc_if_id_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [31:0] instruction_in,
  input  logic [15:0] pc_1_in,
  output logic [15:0] pc_out,
  output logic [31:0] id_instruction,
  output logic [15:0] id_pc_1,
  output logic        id_valid,
  output logic        halted
);

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [PC_W-1:0]    pc_1_nxt;
  logic               valid_nxt;
  logic               halted_nxt;
  logic               is_halt;

  assign is_halt = (instruction_in[INSTR_W-1 -: OP_W] == HALT_OPCODE);

  // Next-state and next-output selection; priority branch > stall > advance.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_out;
    instr_nxt  = id_instruction;
    pc_1_nxt   = id_pc_1;
    valid_nxt  = id_valid;
    halted_nxt = halted;

    case (state)
      RUN: begin
        if (branch_taken) begin
          pc_nxt    = branch_target;
          instr_nxt = NOP_INSTR;
          pc_1_nxt  = PC_W'(0);
          valid_nxt = 1'b0;
        end else if (!stall) begin
          instr_nxt = instruction_in;
          pc_1_nxt  = pc_1_in;
          valid_nxt = 1'b1;
          if (is_halt) begin
            // PC freezes on the halt word so nothing past it is fetched
            halted_nxt = 1'b1;
            state_nxt  = HALTED;
          end else begin
            pc_nxt = pc_1_in;
          end
        end
      end

      HALTED: begin
        if (branch_taken) begin
          // An older in-flight branch resolves after the halt was fetched
          pc_nxt     = branch_target;
          instr_nxt  = NOP_INSTR;
          pc_1_nxt   = PC_W'(0);
          valid_nxt  = 1'b0;
          halted_nxt = 1'b0;
          state_nxt  = RUN;
        end else if (!stall) begin
          instr_nxt = NOP_INSTR;
          pc_1_nxt  = PC_W'(0);
          valid_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State, PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= RUN;
      pc_out         <= RESET_PC;
      id_instruction <= NOP_INSTR;
      id_pc_1        <= PC_W'(0);
      id_valid       <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc_out         <= pc_nxt;
      id_instruction <= instr_nxt;
      id_pc_1        <= pc_1_nxt;
      id_valid       <= valid_nxt;
      halted         <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_pc_if_id_stage.sv
// Directed bench for pc_if_id_stage with a small behavioural fetch stage.
module tb_pc_if_id_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [31:0] instruction_in;
  logic [15:0] pc_1_in;
  logic [15:0] pc_out;
  logic [31:0] id_instruction;
  logic [15:0] id_pc_1;
  logic        id_valid;
  logic        halted;

  logic        force_halt;
  int          checks;
  int          errors;

  pc_if_id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .instruction_in (instruction_in),
    .pc_1_in        (pc_1_in),
    .pc_out         (pc_out),
    .id_instruction (id_instruction),
    .id_pc_1        (id_pc_1),
    .id_valid       (id_valid),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetch stage model: word is 0x1234_0000+pc, or a halt word on request.
  always_comb begin
    if (force_halt) instruction_in = {6'b111111, 10'h000, pc_out};
    else            instruction_in = 32'h1234_0000 + {16'h0000, pc_out};
    pc_1_in = pc_out + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    force_halt = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_instr", id_instruction, 32'h0);
    chk("rst_pc1", 32'(id_pc_1), 32'h0);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // Free run
    rst = 1'b1;
    step();
    chk("run1_pc", 32'(pc_out), 32'h1);
    chk("run1_instr", id_instruction, 32'h1234_0000);
    chk("run1_pc1", 32'(id_pc_1), 32'h1);
    chk("run1_valid", 32'(id_valid), 32'h1);
    step();
    chk("run2_pc", 32'(pc_out), 32'h2);
    chk("run2_pc1", 32'(id_pc_1), 32'h2);
    step();
    chk("run3_pc", 32'(pc_out), 32'h3);
    step();
    step();
    chk("run5_pc", 32'(pc_out), 32'h5);
    chk("run5_instr", id_instruction, 32'h1234_0004);

    // Stall three cycles at pc 5
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(pc_out), 32'h5);
      chk("stall_instr", id_instruction, 32'h1234_0004);
      chk("stall_pc1", 32'(id_pc_1), 32'h5);
    end
    stall = 1'b0;
    step();
    chk("resume_pc", 32'(pc_out), 32'h6);
    chk("resume_instr", id_instruction, 32'h1234_0005);
    step();
    chk("pc7", 32'(pc_out), 32'h7);

    // Branch with coincident stall
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    stall = 1'b1;
    step();
    chk("br_pc", 32'(pc_out), 32'h40);
    chk("br_valid", 32'(id_valid), 32'h0);
    chk("br_instr", id_instruction, 32'h0);
    chk("br_pc1", 32'(id_pc_1), 32'h0);
    branch_taken = 1'b0;
    stall = 1'b0;
    step();
    chk("tgt_instr", id_instruction, 32'h1234_0040);
    chk("tgt_valid", 32'(id_valid), 32'h1);
    chk("tgt_pc", 32'(pc_out), 32'h41);

    // Halt at pc 9
    branch_taken = 1'b1;
    branch_target = 16'h0009;
    step();
    branch_taken = 1'b0;
    force_halt = 1'b1;
    step();
    force_halt = 1'b0;
    chk("halt_instr", id_instruction, 32'hFC00_0009);
    chk("halt_valid", 32'(id_valid), 32'h1);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_pc", 32'(pc_out), 32'h9);
    stall = 1'b1;
    step();
    chk("hstall_instr", id_instruction, 32'hFC00_0009);
    chk("hstall_valid", 32'(id_valid), 32'h1);
    stall = 1'b0;
    step();
    chk("hbub_valid", 32'(id_valid), 32'h0);
    chk("hbub_instr", id_instruction, 32'h0);
    step();
    chk("hbub2_valid", 32'(id_valid), 32'h0);
    chk("hbub2_pc", 32'(pc_out), 32'h9);
    chk("hbub2_halted", 32'(halted), 32'h1);
    branch_taken = 1'b1;
    branch_target = 16'h0002;
    step();
    branch_taken = 1'b0;
    chk("unhalt_flag", 32'(halted), 32'h0);
    chk("unhalt_pc", 32'(pc_out), 32'h2);
    chk("unhalt_valid", 32'(id_valid), 32'h0);
    step();
    chk("unhalt_instr", id_instruction, 32'h1234_0002);
    chk("unhalt_pc3", 32'(pc_out), 32'h3);

    // PC wrap
    branch_taken = 1'b1;
    branch_target = 16'hFFFF;
    step();
    branch_taken = 1'b0;
    chk("wrap_pre", 32'(pc_out), 32'hFFFF);
    step();
    chk("wrap_pc", 32'(pc_out), 32'h0);
    chk("wrap_pc1", 32'(id_pc_1), 32'h0);
    chk("wrap_instr", id_instruction, 32'h1234_FFFF);

    // Reset in HALTED with coincident branch
    force_halt = 1'b1;
    step();
    force_halt = 1'b0;
    chk("h2_flag", 32'(halted), 32'h1);
    rst = 1'b0;
    branch_taken = 1'b1;
    branch_target = 16'h0055;
    step();
    rst = 1'b1;
    branch_taken = 1'b0;
    chk("rsth_pc", 32'(pc_out), 32'h0);
    chk("rsth_halted", 32'(halted), 32'h0);
    chk("rsth_valid", 32'(id_valid), 32'h0);
    step();
    chk("post_rst_pc", 32'(pc_out), 32'h1);

    // Reset pulse between edges is ignored
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    step();
    chk("glitch_pc", 32'(pc_out), 32'h2);
    chk("glitch_valid", 32'(id_valid), 32'h1);
    chk("glitch_pc1", 32'(id_pc_1), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
